segment_histogram_collector: RTL
================================

Name: segment_histogram_collector

Overview:
- Consumer end of the weighted random-choose output.
- Samples a stream of 2-bit segment numbers over a programmable window and counts occurrences per segment (0..3).
- Reports counts plus done/busy/overflow status.
- Used in hardware self-check of the sampler's distribution against its weights, and for on-chip MCMC statistics.

Parameters:
- COUNT_W, 16, width of each per-segment counter and of out_total.
- WINDOW_W, 16, width of the window-length input and of the internal sample counter.

Ports:
- in_clock  input  1  system clock; all logic on rising edge.
- in_reset  input  1  synchronous, active-high reset.
- in_start  input  1  one-cycle pulse; clears counters and opens a window (accepted in IDLE or DONE only).
- in_window_length  input  WINDOW_W  number of samples in the window; latched on accepted in_start.
- in_enable  input  1  sample-valid qualifier for in_segment_number.
- in_segment_number  input  2  segment index produced by the random chooser.
- out_count0..out_count3  output  COUNT_W each  per-segment occurrence counts.
- out_total  output  COUNT_W  total samples accepted in the current window.
- out_busy  output  1  high in COLLECT.
- out_done  output  1  high in DONE; level signal held until the next accepted start or reset.
- out_overflow  output  1  sticky per window; a count saturated.

Behaviour:
- FSM states: IDLE, COLLECT, DONE.
- Reset (synchronous, active-high):
  - state IDLE.
  - All counts, out_total and the internal sample counter 0.
  - out_busy, out_done and out_overflow all 0.
  - Reset wins over every other input in the same cycle.
  - Reset mid-window discards all partial counts.
- IDLE / DONE + in_start:
  - Clear counts, out_total and out_overflow.
  - Latch in_window_length into len_q.
  - If len_q is nonzero, go to COLLECT next cycle; out_busy=1 and out_done=0 from that cycle.
  - If in_window_length==0, go straight to DONE with all counts 0.
- Start-cycle sample: a sample with in_enable=1 in the same cycle as an accepted in_start is NOT counted; counting begins the cycle after.
- COLLECT:
  - Each cycle with in_enable=1, increment out_count[in_segment_number] and out_total.
  - Updated values are visible the next cycle (1-cycle latency).
  - in_enable=0 leaves everything unchanged.
  - in_start is ignored.
- Window close:
  - When a sample is accepted and out_total equals len_q-1, that sample is counted and state goes to DONE.
  - out_done=1 and out_busy=0 in the same cycle the final counts appear.
  - Later samples are ignored until the next start.
- Saturation:
  - A counter at 2^COUNT_W-1 holds its value and sets out_overflow.
  - out_total saturates the same way; when out_total saturates, the window closes.
- Invariant: without overflow, out_count0+out_count1+out_count2+out_count3 == out_total at every cycle.
- DONE: all outputs held stable.

Optional Feature:
- Macro: SEGMENT_HISTOGRAM_ZERO_WEIGHT_CHECK_EN.
- When defined:
  - Adds inputs in_weight0..in_weight3 (8 bits each), latched on accepted in_start.
  - Adds output out_zero_weight_hit (1 bit, reset 0, cleared on start).
  - out_zero_weight_hit is a sticky set when a sample is accepted in COLLECT for a segment whose latched weight is 0.
  - The flag is visible one cycle after the offending sample.
- When undefined: these ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: hold in_reset 2 cycles -> all counts 0, busy=0, done=0, overflow=0; toggling in_enable in IDLE changes nothing.
- Basic window: start with length=8; feed 2,0,1,1,2,1,0,1 with enable=1 -> done 1 cycle after the 8th sample; counts 2,4,2,0; total=8; busy low from that cycle.
- Gapped enable and trailing samples: length=4; enable pattern 1,0,1,1,0,1 then extra samples -> only the 4 qualified samples counted; samples after done are ignored; start pulses during COLLECT are ignored.
- Zero length and restart: start with length=0 -> done next cycle with zero counts; second start with length=3 -> counts cleared, busy=1, window completes normally.
- Reset mid-window: length=10, reset after 5 samples -> IDLE with counts 0; a new start works.
- Saturation (COUNT_W=4): length=20, all samples segment 3 -> out_count3 holds at 15, overflow=1, window closes when total reaches 15. With SEGMENT_HISTOGRAM_ZERO_WEIGHT_CHECK_EN and weights 2,4,2,0, a segment-3 sample sets out_zero_weight_hit.

Source files
------------

// File: rtl/segment_histogram_collector_if.sv
// segment_histogram_collector_if
//   Bundles the window control, sample stream and status/count outputs of
//   segment_histogram_collector.
//   master: drives in_* (sampler/control side), reads out_*.
//   slave : the collector; reads in_*, drives out_*.
//   When SEGMENT_HISTOGRAM_ZERO_WEIGHT_CHECK_EN is defined, adds in_weight0..3
//   and out_zero_weight_hit.
interface segment_histogram_collector_if #(
    parameter int unsigned COUNT_W  = 16,
    parameter int unsigned WINDOW_W = 16
);
    logic                in_start;
    logic [WINDOW_W-1:0] in_window_length;
    logic                in_enable;
    logic [1:0]          in_segment_number;
    logic [COUNT_W-1:0]  out_count0;
    logic [COUNT_W-1:0]  out_count1;
    logic [COUNT_W-1:0]  out_count2;
    logic [COUNT_W-1:0]  out_count3;
    logic [COUNT_W-1:0]  out_total;
    logic                out_busy;
    logic                out_done;
    logic                out_overflow;
`ifdef SEGMENT_HISTOGRAM_ZERO_WEIGHT_CHECK_EN
    logic [7:0]          in_weight0;
    logic [7:0]          in_weight1;
    logic [7:0]          in_weight2;
    logic [7:0]          in_weight3;
    logic                out_zero_weight_hit;
`endif

    modport master (
        output in_start, in_window_length, in_enable, in_segment_number,
`ifdef SEGMENT_HISTOGRAM_ZERO_WEIGHT_CHECK_EN
        output in_weight0, in_weight1, in_weight2, in_weight3,
        input  out_zero_weight_hit,
`endif
        input  out_count0, out_count1, out_count2, out_count3, out_total,
        input  out_busy, out_done, out_overflow
    );

    modport slave (
        input  in_start, in_window_length, in_enable, in_segment_number,
`ifdef SEGMENT_HISTOGRAM_ZERO_WEIGHT_CHECK_EN
        input  in_weight0, in_weight1, in_weight2, in_weight3,
        output out_zero_weight_hit,
`endif
        output out_count0, out_count1, out_count2, out_count3, out_total,
        output out_busy, out_done, out_overflow
    );
endinterface

// File: rtl/segment_histogram_collector.sv
// segment_histogram_collector
//   Counts occurrences of 2-bit segment numbers over a programmable window of
//   qualified samples and reports per-segment counts, total and status.
// Ports:
//   in_clock  - system clock, rising edge
//   in_reset  - synchronous active-high reset
//   hist_if   - segment_histogram_collector_if.slave:
//               in_start, in_window_length, in_enable, in_segment_number,
//               out_count0..3, out_total, out_busy, out_done, out_overflow
// Optional: define SEGMENT_HISTOGRAM_ZERO_WEIGHT_CHECK_EN to add latched
//   per-segment weights and a sticky out_zero_weight_hit flag.
module segment_histogram_collector #(
    parameter int unsigned COUNT_W  = 16,
    parameter int unsigned WINDOW_W = 16
) (
    input  logic                            in_clock,
    input  logic                            in_reset,
    segment_histogram_collector_if.slave    hist_if
);
    typedef enum logic [1:0] {StIdle, StCollect, StDone} state_t;

    localparam logic [COUNT_W-1:0]  CntMax   = '1;
    localparam logic [COUNT_W-1:0]  CntOne   = COUNT_W'(1);
    localparam logic [WINDOW_W-1:0] WinOne   = WINDOW_W'(1);

    state_t              r_state;
    logic [COUNT_W-1:0]  r_count [4];
    logic [COUNT_W-1:0]  r_total;
    logic [WINDOW_W-1:0] r_sample_cnt;
    logic [WINDOW_W-1:0] r_len;
    logic                r_busy;
    logic                r_done;
    logic                r_overflow;

    logic                w_sample;
    logic                w_last;
    logic [COUNT_W-1:0]  w_seg_cur;

`ifdef SEGMENT_HISTOGRAM_ZERO_WEIGHT_CHECK_EN
    logic [7:0]          r_weight [4];
    logic                r_zero_hit;
`endif

    always_comb begin
        w_sample  = (r_state == StCollect) && hist_if.in_enable;
        w_seg_cur = r_count[hist_if.in_segment_number];
        // Window closes on the sample that reaches the programmed length, or
        // on the one that drives the total into saturation.
        w_last    = (r_sample_cnt == (r_len - WinOne)) || (r_total == (CntMax - CntOne));
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            r_state      <= StIdle;
            for (int i = 0; i < 4; i++) r_count[i] <= '0;
            r_total      <= '0;
            r_sample_cnt <= '0;
            r_len        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
`ifdef SEGMENT_HISTOGRAM_ZERO_WEIGHT_CHECK_EN
            for (int i = 0; i < 4; i++) r_weight[i] <= '0;
            r_zero_hit   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    // A sample in the start cycle is deliberately not counted.
                    if (hist_if.in_start) begin
                        for (int i = 0; i < 4; i++) r_count[i] <= '0;
                        r_total      <= '0;
                        r_sample_cnt <= '0;
                        r_overflow   <= 1'b0;
                        r_len        <= hist_if.in_window_length;
`ifdef SEGMENT_HISTOGRAM_ZERO_WEIGHT_CHECK_EN
                        r_weight[0]  <= hist_if.in_weight0;
                        r_weight[1]  <= hist_if.in_weight1;
                        r_weight[2]  <= hist_if.in_weight2;
                        r_weight[3]  <= hist_if.in_weight3;
                        r_zero_hit   <= 1'b0;
`endif
                        if (hist_if.in_window_length == '0) begin
                            r_state <= StDone;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= StCollect;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                end
                StCollect: begin
                    if (w_sample) begin
                        if (w_seg_cur == CntMax) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_count[hist_if.in_segment_number] <= w_seg_cur + CntOne;
                            if ((w_seg_cur + CntOne) == CntMax) r_overflow <= 1'b1;
                        end
                        if (r_total != CntMax) begin
                            r_total <= r_total + CntOne;
                            if ((r_total + CntOne) == CntMax) r_overflow <= 1'b1;
                        end
                        r_sample_cnt <= r_sample_cnt + WinOne;
`ifdef SEGMENT_HISTOGRAM_ZERO_WEIGHT_CHECK_EN
                        if (r_weight[hist_if.in_segment_number] == 8'd0) r_zero_hit <= 1'b1;
`endif
                        if (w_last) begin
                            r_state <= StDone;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign hist_if.out_count0   = r_count[0];
    assign hist_if.out_count1   = r_count[1];
    assign hist_if.out_count2   = r_count[2];
    assign hist_if.out_count3   = r_count[3];
    assign hist_if.out_total    = r_total;
    assign hist_if.out_busy     = r_busy;
    assign hist_if.out_done     = r_done;
    assign hist_if.out_overflow = r_overflow;
`ifdef SEGMENT_HISTOGRAM_ZERO_WEIGHT_CHECK_EN
    assign hist_if.out_zero_weight_hit = r_zero_hit;
`endif
endmodule
